// File: rtl/moonbase_io_bridge.sv
// I/O bridge for the moonbase 8-bit CPU: address latch, nibble-wide code/data SRAM,
// and a small device bus (GPIO, 8N1 UART transmitter, reload timer).
module moonbase_io_bridge #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PRESCALE     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_out,
  output logic [3:0] ram_out,
  output logic [1:0] dev_out,
  input  logic       ld_en,
  input  logic [8:0] ld_addr,
  input  logic [3:0] ld_data,
  output logic [7:0] gpio_out,
  input  logic [3:0] gpio_in,
  output logic       uart_tx
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PreW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // Bus decode and address/nibble tracking
  logic       strobe;
  logic       eff_bank;
  logic [6:0] addr_q;
  logic       nib_q;
  logic       bank_q;
  logic [3:0] wlo_q;
  logic [7:0] gpio_q;

  assign strobe   = cpu_out[7];
  assign eff_bank = strobe ? bank_q : cpu_out[6];

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      nib_q  <= 1'b0;
      bank_q <= 1'b0;
    end else if (strobe) begin
      addr_q <= cpu_out[6:0];
      nib_q  <= 1'b0;
    end else begin
      nib_q  <= 1'b1;
      bank_q <= cpu_out[6];
    end
  end

  // Memory: each byte kept as two nibble arrays indexed by {bank, addr}
  logic [3:0] mem_lo [256];
  logic [3:0] mem_hi [256];
  logic       wr_en;
  logic [7:0] wr_idx;
  logic       wr_nib;
  logic [3:0] wr_data;
  logic [7:0] rd_idx;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = {cpu_out[6], addr_q};
    wr_nib  = nib_q;
    wr_data = cpu_out[3:0];
    if (ld_en) begin
      // Load port has priority and suppresses the CPU write entirely.
      wr_en   = 1'b1;
      wr_idx  = ld_addr[8:1];
      wr_nib  = ld_addr[0];
      wr_data = ld_data;
    end else if (!strobe && !cpu_out[5]) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_nib) begin
        mem_hi[wr_idx] <= wr_data;
      end else begin
        mem_lo[wr_idx] <= wr_data;
      end
    end
  end

  assign rd_idx  = {eff_bank, addr_q};
  assign ram_out = nib_q ? mem_hi[rd_idx] : mem_lo[rd_idx];

  // Device writes: nibble 0 is staged, nibble 1 commits the full byte
  logic       dev_we;
  logic       commit;
  logic [7:0] commit_byte;
  logic       gpio_wr;
  logic       uart_wr;
  logic       tmr_wr;

  assign dev_we      = !strobe && !cpu_out[4];
  assign commit      = dev_we && nib_q;
  assign commit_byte = {cpu_out[3:0], wlo_q};
  assign gpio_wr     = commit && (addr_q == 7'h00);
  assign uart_wr     = commit && (addr_q == 7'h02);
  assign tmr_wr      = commit && (addr_q == 7'h03);

  always_ff @(posedge clk) begin
    if (reset) begin
      wlo_q  <= '0;
      gpio_q <= '0;
    end else begin
      if (dev_we && !nib_q) begin
        wlo_q <= cpu_out[3:0];
      end
      if (gpio_wr) begin
        gpio_q <= commit_byte;
      end
    end
  end

  assign gpio_out = gpio_q;

  // UART transmitter
  logic [1:0]       state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;
  logic             tx_busy;

  assign bit_end = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign tx_busy = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      StIdle: begin
        if (uart_wr) begin
          state_d = StStart;
          baud_d  = '0;
          shift_d = commit_byte;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            // shift_q[0] is always the bit currently on the line
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx = tx_q;

  // Reload timer
  logic [PreW-1:0] presc_q, presc_d;
  logic [7:0]      reload_q, reload_d;
  logic [7:0]      count_q, count_d;
  logic            flag_q, flag_d;
  logic            tick;

  assign tick = (presc_q == PreW'(PRESCALE - 1));

  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    reload_d = reload_q;
    count_d  = count_q;
    flag_d   = flag_q;
    if (tick && (reload_q != 8'd0)) begin
      if (count_q == 8'd1) begin
        flag_d  = 1'b1;
        count_d = reload_q;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
    // A register write overrides a coincident tick.
    if (tmr_wr) begin
      reload_d = commit_byte;
      count_d  = commit_byte;
      presc_d  = '0;
      flag_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      reload_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Device read mux
  always_comb begin
    dev_out = 2'b00;
    case (addr_q)
      7'h00:   dev_out = gpio_in[1:0];
      7'h01:   dev_out = gpio_in[3:2];
      7'h02:   dev_out = {tx_busy, flag_q};
      default: dev_out = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_moonbase_io_bridge.sv
// Scoreboard bench for moonbase_io_bridge: a queue/arithmetic reference model predicts every
// cycle's outputs; a negedge monitor pops and compares. Directed scenarios add fixed checks.
module tb_moonbase_io_bridge;

  localparam int CPB = 16;
  localparam int PRE = 4;

  logic       clk;
  logic       reset;
  logic [7:0] cpu_out;
  logic [3:0] ram_out;
  logic [1:0] dev_out;
  logic       ld_en;
  logic [8:0] ld_addr;
  logic [3:0] ld_data;
  logic [7:0] gpio_out;
  logic [3:0] gpio_in;
  logic       uart_tx;

  moonbase_io_bridge #(
    .CLKS_PER_BIT(CPB),
    .PRESCALE    (PRE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cpu_out (cpu_out),
    .ram_out (ram_out),
    .dev_out (dev_out),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .gpio_out(gpio_out),
    .gpio_in (gpio_in),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] ram;
    logic [1:0] dev;
    logic       tx;
    logic [7:0] gpio;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model state
  logic [7:0] m_mem [2][128];
  logic [6:0] m_addr = '0;
  bit         m_nib = 0;
  bit         m_bank = 0;
  logic [3:0] m_wlo = '0;
  logic [7:0] m_gpio = '0;
  int         m_reload = 0;
  int         m_count = 0;
  int         m_presc = 0;
  bit         m_flag = 0;
  bit         m_txq[$];  // line level for each upcoming cycle of the current frame
  bit         m_valid = 0;

  // Stimulus applied by step()
  logic       t_rst = 1'b1;
  logic       t_ld_en = 1'b0;
  logic [8:0] t_ld_addr = '0;
  logic [3:0] t_ld_data = '0;
  logic [3:0] t_gpio = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_nib(input bit b, input logic [6:0] a, input bit n, input logic [3:0] d);
    if (n) m_mem[b][a][7:4] = d;
    else m_mem[b][a][3:0] = d;
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic model_edge();
    logic [7:0] c;
    logic [7:0] by;
    bit strobe, commit, was_busy, tick, v;
    c = cpu_out;
    strobe = c[7];
    if (ld_en) write_nib(ld_addr[8], ld_addr[7:1], ld_addr[0], ld_data);
    else if (!strobe && !c[5]) write_nib(c[6], m_addr, m_nib, c[3:0]);
    if (reset) begin
      m_addr = '0; m_nib = 0; m_bank = 0; m_wlo = '0; m_gpio = '0;
      m_reload = 0; m_count = 0; m_presc = 0; m_flag = 0;
      m_txq.delete();
      m_valid = 1;
      return;
    end
    if (!m_valid) return;
    commit = !strobe && !c[4] && m_nib;
    by = {c[3:0], m_wlo};
    if (!strobe && !c[4] && !m_nib) m_wlo = c[3:0];
    if (commit && m_addr == 7'd0) m_gpio = by;
    was_busy = (m_txq.size() != 0);
    if (was_busy) void'(m_txq.pop_front());
    if (commit && m_addr == 7'd2 && !was_busy) begin
      for (int i = 0; i < 10; i++) begin
        v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : by[i-1];
        repeat (CPB) m_txq.push_back(v);
      end
    end
    tick = (m_presc == PRE - 1);
    m_presc = tick ? 0 : m_presc + 1;
    if (tick && m_reload != 0) begin
      if (m_count == 1) begin
        m_flag = 1;
        m_count = m_reload;
      end else begin
        m_count = m_count - 1;
      end
    end
    if (commit && m_addr == 7'd3) begin
      m_reload = by; m_count = by; m_presc = 0; m_flag = 0;
    end
    if (strobe) begin
      m_addr = c[6:0];
      m_nib = 0;
    end else begin
      m_nib = 1;
      m_bank = c[6];
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic [7:0] by;
    bit eb;
    eb = cpu_out[7] ? m_bank : cpu_out[6];
    by = m_mem[eb][m_addr];
    e.ram = m_nib ? by[7:4] : by[3:0];
    case (m_addr)
      7'd0:    e.dev = gpio_in[1:0];
      7'd1:    e.dev = gpio_in[3:2];
      7'd2:    e.dev = {m_txq.size() != 0, m_flag};
      default: e.dev = 2'b00;
    endcase
    e.tx = (m_txq.size() != 0) ? m_txq[0] : 1'b1;
    e.gpio = m_gpio;
    return e;
  endfunction

  task automatic step(input logic [7:0] c);
    @(posedge clk);
    model_edge();
    #1;
    cpu_out = c;
    reset = t_rst;
    ld_en = t_ld_en;
    ld_addr = t_ld_addr;
    ld_data = t_ld_data;
    gpio_in = t_gpio;
    #3;
    if (m_valid) sb_q.push_back(predict());
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("sb_ram_out", 32'(ram_out), 32'(mon_e.ram));
      chk("sb_dev_out", 32'(dev_out), 32'(mon_e.dev));
      chk("sb_uart_tx", 32'(uart_tx), 32'(mon_e.tx));
      chk("sb_gpio_out", 32'(gpio_out), 32'(mon_e.gpio));
    end
  end

  logic [7:0] frame_55;
  logic [7:0] rc;

  initial begin
    reset = 1'b1; cpu_out = 8'h80; ld_en = 1'b0; ld_addr = '0; ld_data = '0; gpio_in = '0;
    frame_55 = 8'h55;

    // Reset state
    t_rst = 1'b1; t_gpio = 4'b0110;
    repeat (3) step(8'h80);
    t_rst = 1'b0;
    step(8'h80);
    chk("reset_uart_tx", 32'(uart_tx), 32'd1);
    chk("reset_gpio_out", 32'(gpio_out), 32'd0);
    chk("reset_dev_out", 32'(dev_out), 32'd2);

    // Preload all memory through the load port
    t_ld_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      t_ld_addr = 9'(i);
      t_ld_data = 4'($urandom);
      step(8'h80);
    end

    // Code load and nibble readback
    t_ld_addr = {1'b1, 7'h03, 1'b0}; t_ld_data = 4'hA; step(8'h80);
    t_ld_addr = {1'b1, 7'h03, 1'b1}; t_ld_data = 4'h5; step(8'h80);
    t_ld_en = 1'b0;
    step(8'h83);
    step(8'h40); chk("code_nib0", 32'(ram_out), 32'hA);
    step(8'h40); chk("code_nib1", 32'(ram_out), 32'h5);

    // Data write then readback
    step(8'h85); step(8'h13); step(8'h14);
    step(8'h85);
    step(8'h00); chk("data_nib0", 32'(ram_out), 32'h3);
    step(8'h00); chk("data_nib1", 32'(ram_out), 32'h4);

    // UART frame 0x55
    step(8'h82); step(8'h25); step(8'h25);
    for (int k = 0; k < 160; k++) begin
      step(8'h82);
      chk("uart_bit", 32'(uart_tx),
          (k < 16) ? 32'd0 : (k >= 144) ? 32'd1 : 32'(frame_55[k/16-1]));
      chk("uart_busy", 32'(dev_out[1]), 32'd1);
    end
    step(8'h82);
    chk("uart_idle_tx", 32'(uart_tx), 32'd1);
    chk("uart_idle_busy", 32'(dev_out[1]), 32'd0);

    // Timer reload 2: flag 8 cycles after commit, sticky, cleared by rewrite
    step(8'h83); step(8'h22); step(8'h20);
    for (int j = 1; j <= 12; j++) begin
      step(8'h82);
      if (j >= 2) chk("timer_flag", 32'(dev_out[0]), (j >= 9) ? 32'd1 : 32'd0);
    end
    step(8'h83); step(8'h20); step(8'h20);
    step(8'h82); step(8'h82);
    chk("timer_clear", 32'(dev_out[0]), 32'd0);

    // GPIO write and reads
    t_gpio = 4'b1001;
    step(8'h80); step(8'h23); step(8'h2C);
    step(8'h80);
    chk("gpio_out", 32'(gpio_out), 32'hC3);
    chk("gpio_rd0", 32'(dev_out), 32'd1);
    step(8'h81); step(8'h80);
    chk("gpio_rd1", 32'(dev_out), 32'd2);

    // Reset during third data bit of a 0x5A frame
    step(8'h82); step(8'h2A); step(8'h25);
    for (int k = 0; k < 50; k++) step(8'h82);
    chk("frame_bit2", 32'(uart_tx), 32'd0);
    t_rst = 1'b1; step(8'h82);
    t_rst = 1'b0; step(8'h82);
    chk("abort_tx", 32'(uart_tx), 32'd1);
    chk("abort_gpio", 32'(gpio_out), 32'd0);
    step(8'h82);
    chk("abort_busy", 32'(dev_out[1]), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 35) begin
        rc = 8'h80 | (($urandom_range(0, 4) == 4) ? 8'($urandom_range(0, 127))
                                                  : 8'($urandom_range(0, 3)));
      end else begin
        rc = {1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom)};
      end
      t_ld_en = ($urandom_range(0, 9) == 0);
      t_ld_addr = 9'($urandom);
      t_ld_data = 4'($urandom);
      t_gpio = 4'($urandom);
      t_rst = ($urandom_range(0, 499) == 0);
      step(rc);
    end
    t_rst = 1'b0; t_ld_en = 1'b0;
    repeat (4) step(8'h80);

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
